// File: rtl/sop_pkg.sv
// Shared types and defaults for the sum-of-products sequencer.
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_TERMS = 4;

    // Accumulator width that can never overflow for the given operand width and term count.
    function automatic int unsigned acc_w_f(input int unsigned width, input int unsigned terms);
        return 2 * width + $clog2(terms);
    endfunction

endpackage

// File: rtl/sop_if.sv
// Operand/result handshake bundle between the sequencer and the system.
interface sop_if #(
    parameter int unsigned WIDTH = sop_pkg::DEF_WIDTH,
    parameter int unsigned ACC_W = sop_pkg::acc_w_f(sop_pkg::DEF_WIDTH, sop_pkg::DEF_TERMS)
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    modport master (
        output start, a_in, b_in, in_valid, result_ready,
        input  in_ready, result, result_valid, busy
    );

    modport slave (
        input  start, a_in, b_in, in_valid, result_ready,
        output in_ready, result, result_valid, busy
    );
endinterface

// File: rtl/sop_mac_unit.sv
// Multiply/accumulate datapath: clearable registered accumulator fed by a*b.
// Optional SOP_SATURATE_EN clamps the sum at all-ones instead of wrapping.
module sop_mac_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [ACC_W-1:0] acc_nxt_o
);
    localparam int unsigned PROD_W = 2 * WIDTH;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  add_res;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;

    assign prod = PROD_W'(a_i) * PROD_W'(b_i);

`ifdef SOP_SATURATE_EN
    localparam int unsigned SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({ACC_W{1'b1}});
    logic [SUM_W-1:0] sum_wide;

    // Unsigned add never decreases, so a clamped sum stays clamped until cleared.
    assign sum_wide = SUM_W'(acc_q) + SUM_W'(prod);
    assign add_res  = (sum_wide > SAT_MAX) ? {ACC_W{1'b1}} : ACC_W'(sum_wide);
`else
    assign add_res = acc_q + ACC_W'(prod);
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = add_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_nxt_o = acc_d;
endmodule

// File: rtl/sop_sequencer.sv
// Sum-of-products sequencer: collects TERMS (a,b) pairs into the MAC and hands
// back the sum with a valid/ready handshake. Datapath option: SOP_SATURATE_EN.
module sop_sequencer
    import sop_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned TERMS = DEF_TERMS,
    parameter int unsigned ACC_W = acc_w_f(WIDTH, TERMS)
) (
    input logic  clk,
    input logic  rst,
    sop_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TERMS) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mac_clr, mac_en;
    logic [ACC_W-1:0] acc_nxt;

    logic             in_ready_q;
    logic             result_valid_q;
    logic             busy_q;
    logic [ACC_W-1:0] result_q;

    sop_mac_unit #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (mac_clr),
        .en_i      (mac_en),
        .a_i       (bus.a_in),
        .b_i       (bus.b_in),
        .acc_nxt_o (acc_nxt)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    count_d = '0;
                    mac_clr = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    mac_en  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(TERMS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A start coinciding with the handshake is deliberately dropped.
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            in_ready_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            in_ready_q     <= (state_d == ACCUM);
            result_valid_q <= (state_d == DONE);
            busy_q         <= (state_d != IDLE);
            result_q       <= (state_d == DONE) ? acc_nxt : '0;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
endmodule

// File: tb/tb_sop_sequencer.sv
// Directed bench for sop_sequencer: default build, narrow-accumulator and TERMS=1 instances.
module tb_sop_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sop_if #(.WIDTH(4), .ACC_W(10)) m_if ();
    sop_if #(.WIDTH(4), .ACC_W(8))  o_if ();
    sop_if #(.WIDTH(4), .ACC_W(8))  t_if ();

    sop_sequencer #(.WIDTH(4), .TERMS(4), .ACC_W(10)) u_main (.clk(clk), .rst(rst), .bus(m_if.slave));
    sop_sequencer #(.WIDTH(4), .TERMS(4), .ACC_W(8))  u_ovf  (.clk(clk), .rst(rst), .bus(o_if.slave));
    sop_sequencer #(.WIDTH(4), .TERMS(1), .ACC_W(8))  u_one  (.clk(clk), .rst(rst), .bus(t_if.slave));

    int n_checks  = 0;
    int n_fail    = 0;
    int n_accepts = 0;

    logic [3:0] ta [4] = '{4'd3, 4'd2, 4'd15, 4'd1};
    logic [3:0] tb [4] = '{4'd5, 4'd7, 4'd15, 4'd1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        if (m_if.in_valid && m_if.in_ready) n_accepts++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_if.start = 0; m_if.a_in = 0; m_if.b_in = 0; m_if.in_valid = 0; m_if.result_ready = 0;
        o_if.start = 0; o_if.a_in = 0; o_if.b_in = 0; o_if.in_valid = 0; o_if.result_ready = 0;
        t_if.start = 0; t_if.a_in = 0; t_if.b_in = 0; t_if.in_valid = 0; t_if.result_ready = 0;

        // Reset state
        tick(); tick();
        rst = 0;
        chk("rst_in_ready",     32'(m_if.in_ready),     0);
        chk("rst_result",       32'(m_if.result),       0);
        chk("rst_result_valid", 32'(m_if.result_valid), 0);
        chk("rst_busy",         32'(m_if.busy),         0);
        tick();
        chk("idle_busy", 32'(m_if.busy), 0);

        // Basic back-to-back run: 15+14+225+1 = 255
        m_if.start = 1; tick(); m_if.start = 0;
        chk("basic_busy",     32'(m_if.busy),     1);
        chk("basic_in_ready", 32'(m_if.in_ready), 1);
        n_accepts = 0;
        for (int i = 0; i < 4; i++) begin
            m_if.in_valid = 1; m_if.a_in = ta[i]; m_if.b_in = tb[i];
            tick();
            if (i == 2) chk("basic_no_early_valid", 32'(m_if.result_valid), 0);
        end
        m_if.in_valid = 0;
        chk("basic_result_valid", 32'(m_if.result_valid), 1);
        chk("basic_result",       32'(m_if.result),       255);
        chk("basic_in_ready_lo",  32'(m_if.in_ready),     0);
        chk("basic_accepts",      32'(n_accepts),         4);
        m_if.result_ready = 1; tick(); m_if.result_ready = 0;
        chk("basic_hs_valid",  32'(m_if.result_valid), 0);
        chk("basic_hs_busy",   32'(m_if.busy),         0);
        chk("basic_hs_result", 32'(m_if.result),       0);

        // Stalls of two cycles between terms
        m_if.start = 1; tick(); m_if.start = 0;
        n_accepts = 0;
        for (int i = 0; i < 4; i++) begin
            m_if.in_valid = 1; m_if.a_in = ta[i]; m_if.b_in = tb[i];
            tick();
            m_if.in_valid = 0;
            if (i < 3) begin
                for (int s = 0; s < 2; s++) begin
                    chk("stall_in_ready", 32'(m_if.in_ready), 1);
                    tick();
                end
            end
        end
        chk("stall_result_valid", 32'(m_if.result_valid), 1);
        chk("stall_result",       32'(m_if.result),       255);
        chk("stall_accepts",      32'(n_accepts),         4);

        // Backpressure with start held high: no restart, result stable
        m_if.start = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_result_valid", 32'(m_if.result_valid), 1);
            chk("bp_result",       32'(m_if.result),       255);
        end
        m_if.result_ready = 1; tick(); m_if.result_ready = 0; m_if.start = 0;
        chk("bp_hs_busy",  32'(m_if.busy),         0);
        chk("bp_hs_valid", 32'(m_if.result_valid), 0);
        tick();
        chk("bp_start_dropped", 32'(m_if.busy), 0);

        // Reset mid-computation after two terms
        m_if.start = 1; tick(); m_if.start = 0;
        for (int i = 0; i < 2; i++) begin
            m_if.in_valid = 1; m_if.a_in = ta[i]; m_if.b_in = tb[i];
            tick();
        end
        m_if.in_valid = 0; rst = 1; tick(); rst = 0;
        chk("mid_rst_in_ready",     32'(m_if.in_ready),     0);
        chk("mid_rst_result",       32'(m_if.result),       0);
        chk("mid_rst_result_valid", 32'(m_if.result_valid), 0);
        chk("mid_rst_busy",         32'(m_if.busy),         0);
        m_if.start = 1; tick(); m_if.start = 0;
        m_if.in_valid = 1; m_if.a_in = 4'd15; m_if.b_in = 4'd15;
        repeat (4) tick();
        m_if.in_valid = 0;
        chk("max_result_valid", 32'(m_if.result_valid), 1);
        chk("max_result",       32'(m_if.result),       900);
        m_if.result_ready = 1; tick(); m_if.result_ready = 0;

        // Narrow accumulator: 4 x 225 = 900 wraps to 132 or clamps to 255
        o_if.start = 1; tick(); o_if.start = 0;
        o_if.in_valid = 1; o_if.a_in = 4'd15; o_if.b_in = 4'd15;
        repeat (4) tick();
        o_if.in_valid = 0;
        chk("ovf_result_valid", 32'(o_if.result_valid), 1);
`ifdef SOP_SATURATE_EN
        chk("ovf_result", 32'(o_if.result), 255);
`else
        chk("ovf_result", 32'(o_if.result), 132);
`endif

        // TERMS=1: one accept goes straight to DONE
        t_if.start = 1; tick(); t_if.start = 0;
        chk("one_in_ready", 32'(t_if.in_ready), 1);
        t_if.in_valid = 1; t_if.a_in = 4'd9; t_if.b_in = 4'd9;
        tick();
        t_if.in_valid = 0;
        chk("one_result_valid", 32'(t_if.result_valid), 1);
        chk("one_result",       32'(t_if.result),       81);
        t_if.result_ready = 1; tick(); t_if.result_ready = 0;
        chk("one_hs_busy", 32'(t_if.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
